data_mem_responder: RTL

Data-memory responder at the far end of the MEM stage's load/store port. Accepts one word-wide request at a time over a req/ack handshake, inserts a configurable number of wait states, then commits the byte-lane write or returns the read word with a single-cycle acknowledge. Out-of-range addresses and empty byte selects are rejected with an error acknowledge, and memory is left unchanged. Storage is an internal word array; contents are not cleared by reset.

---
 rtl/data_mem_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-wide data memory behind a req/ack port.
// A request is accepted in IDLE, waits WAIT_CYCLES cycles, then commits
// (store) or captures read data (load) on the edge that enters RESP.
// During RESP a single-cycle ack (with an error qualifier) is presented.
//
// Handshake: the initiator raises mem_req_i with stable fields and holds it
// until it sees mem_ack_o high for one cycle, then drops mem_req_i in the
// following cycle. A request is sampled only in IDLE; anything that changes
// on the inputs after acceptance is ignored in favour of the latched copy.
module data_mem_responder #(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        mem_err_o,
    output logic [1:0]  dbg_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;

    // Latched request fields; byte-offset bits of the address are not kept.
    logic        r_we;
    logic [31:2] r_addr;
    logic [3:0]  r_sel;
    logic [31:0] r_wdata;

    // Effective request: live inputs while IDLE (covers the zero-wait case,
    // where RESP is entered on the accepting edge), latched copy otherwise.
    logic                  e_we;
    logic [31:2]           e_addr;
    logic [3:0]            e_sel;
    logic [31:0]           e_wdata;
    logic                  bad;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  enter_resp;
    logic                  addr_lsb_unused;

    logic [31:0] mem [DEPTH];

    assign addr_lsb_unused = ^mem_addr_i[1:0];
    assign dbg_state       = state;

    assign e_we    = (state == S_IDLE) ? mem_we_i           : r_we;
    assign e_addr  = (state == S_IDLE) ? mem_addr_i[31:2]   : r_addr;
    assign e_sel   = (state == S_IDLE) ? mem_sel_i          : r_sel;
    assign e_wdata = (state == S_IDLE) ? mem_wdata_i        : r_wdata;

    assign bad = (e_addr[31:DEPTH_LOG2+2] != BASE_ADDR[31:DEPTH_LOG2+2]) || (e_sel == 4'b0000);
    assign idx = e_addr[DEPTH_LOG2+1:2];
    assign enter_resp = (state != S_RESP) && (state_nx == S_RESP);

    // Next-state and wait counter logic.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (mem_req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nx = S_RESP;
                    end else begin
                        state_nx = S_WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = S_RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State and counter registers; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Capture the request fields when a request is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && mem_req_i) begin
            r_we    <= mem_we_i;
            r_addr  <= mem_addr_i[31:2];
            r_sel   <= mem_sel_i;
            r_wdata <= mem_wdata_i;
        end
    end

    // Registered response: ack/err pulse and load data, updated on RESP entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ack_o   <= 1'b0;
            mem_err_o   <= 1'b0;
            mem_rdata_o <= 32'h0;
        end else begin
            mem_ack_o <= enter_resp;
            mem_err_o <= enter_resp && bad;
            if (enter_resp) begin
                if (bad) begin
                    mem_rdata_o <= 32'h0;
                end else if (!e_we) begin
                    mem_rdata_o <= mem[idx];
                end
            end
        end
    end

    // Byte-lane store commit; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && !bad && e_we) begin
            for (int i = 0; i < 4; i++) begin
                if (e_sel[i]) begin
                    mem[idx][i*8 +: 8] <= e_wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule
